mxint8_quantizer: RTL and testbench
===================================

# mxint8_quantizer

Streaming encoder that converts signed fixed-point elements into one OCP MXINT8 block: a shared E8M0 scale plus BLOCK_SIZE 8-bit elements. It accepts one wide element per cycle and finds the block's maximum magnitude. It then derives the shared scale and rounds and saturates each element serially. The block-parallel output has the same format that `mxint8_add_sub` consumes on its A/B operands, so a quantizer feeds that arithmetic stage directly.

## Interface
- `IN_WIDTH`, 16: width of the signed two's-complement input element.
- `IN_FRAC_BITS`, 8: fraction bits of the input. Value = raw × 2^-IN_FRAC_BITS.
- Constants from `mxint8_includes.v`:
  - `SCALE_WIDTH` = 8
  - `MXINT8_ELEMENT_WIDTH` = 8
  - `BLOCK_SIZE` = 32
- `i_clk` input 1: single clock. All logic is rising-edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: input element valid.
- `o_ready` output 1: quantizer accepts an input element this cycle.
- `i_element` input IN_WIDTH: signed fixed-point input element.
- `o_valid` output 1: output block valid.
- `i_ready` input 1: downstream accepts the block.
- `o_scale` output SCALE_WIDTH: E8M0 shared scale, bias 127.
- `o_mxint8_elements` output [BLOCK_SIZE-1:0] × MXINT8_ELEMENT_WIDTH: two's-complement elements. Each element value = raw × 2^-6.

## Operation
- States:
  - COLLECT: `o_ready`=1. Each handshake (`i_valid & o_ready`) writes the element to `buf[idx]`, increments `idx` and updates `max_abs`. After the handshake at `idx`=BLOCK_SIZE-1, go to SCALE.
  - SCALE: one cycle. Compute the block exponent and the scale.
  - CONVERT: BLOCK_SIZE cycles. One element per cycle, index 0 upward, written into the output register.
  - OUTPUT: `o_valid`=1 and outputs held stable. On `i_ready`, go to COLLECT; `idx` and `max_abs` are cleared.
- Arithmetic:
  - `max_abs` is IN_WIDTH+1 bits unsigned, so |−2^(IN_WIDTH-1)| is exact.
  - `p` = bit position of the most-significant one in `max_abs`.
  - X = p − IN_FRAC_BITS (signed). `o_scale` = clamp(X+127, 0, 254). The NaN code 255 is never produced.
  - Let s = p − 6 (signed).
    - If s > 0: q = round-to-nearest-even(raw / 2^s).
    - If s ≤ 0: q = raw << −s, which is exact.
    - Then saturate q to [−127, +127]. −128 is never produced.
- Zero block (`max_abs`=0): `o_scale`=0 and all elements are 0.
- Scale clamping:
  - If X+127 < 0: scale is 0 and elements are computed with the clamped exponent. The shift grows by the clamp amount and elements may underflow to 0.
  - If X+127 > 254: scale is 254. Clamping at 254 is unreachable for legal parameters; the implementation asserts it.

## Timing
- Reset values:
  - `o_ready`=0 while reset is asserted, 1 in the first cycle after release (state COLLECT).
  - `o_valid`=0, `o_scale`=0, all `o_mxint8_elements`=0.
  - `idx`=0, `max_abs`=0.
- Latency: if the last input handshake occurs in cycle t, `o_valid` first rises in cycle t+BLOCK_SIZE+2.
- `o_ready` is 0 in SCALE, CONVERT and OUTPUT. There is no overlap between blocks.
- Throughput: one block per 2×BLOCK_SIZE+2 cycles at best.
- `i_valid` gaps in COLLECT stall `idx`. The state does not change.
- `o_valid` stays high until `i_ready`. `o_scale` and `o_mxint8_elements` do not change while `o_valid`=1 and `i_ready`=0.
- The OUTPUT→COLLECT transition happens on the handshake edge. `o_ready`=1 in the next cycle and `o_valid` drops the same cycle.
- Asserting `i_rst_n` mid-block discards the partial block immediately and returns all values to reset.

## Structure
- `mxint8_includes.v` gets:
  - `SCALE_BIAS`=127, `SCALE_MAX`=254
  - `MXINT8_FRAC_BITS`=6
  - `MXINT8_ELEM_MAX`=127
  - state encodings `Q_COLLECT`, `Q_SCALE`, `Q_CONVERT`, `Q_OUTPUT`
- Sub-module `mxint8_msb_detect`: combinational priority encoder giving `p` and a zero flag from `max_abs`. It is reused by later normalizing blocks.
- Rounding and saturation form one combinational path inside the quantizer, shared by all elements because conversion is serial.

## Test plan
Defaults: BLOCK_SIZE=32, IN_WIDTH=16, IN_FRAC_BITS=8.
1. All inputs 0x0100 (1.0) → `o_scale`=127, all elements 64. `o_valid` rises 34 cycles after the last input handshake.
2. Element 0 = 0x7FFF, rest 0 → `o_scale`=133 and element 0 = 127 (128 saturated). Element 0 = −32768, rest 0 → `o_scale`=134 and element 0 = −64.
3. Max 0x0100 (s=2), other elements 0x0003, 0x0002, 0x0006, 0xFFFA → 1, 0, 2, −2 (ties go to even).
4. All-zero block → `o_scale`=0, all elements 0. A single 0x0001 with the rest 0 → `o_scale`=119, that element 64.
5. Random `i_valid` gaps, plus `i_ready` held low for 10 cycles in OUTPUT → `o_ready` stays 0 and outputs stay stable. Results match the reference model, and the next block is accepted the cycle after the handshake.
6. Deassert `i_rst_n` after 17 inputs, then release and send a full block → outputs are 0 during reset and the new block is unaffected by the partial one.

Source files
------------

// File: rtl/mxint8_quantizer_pkg.sv
// -----------------------------------------------------------------------------
// mxint8_quantizer_pkg
// Shared constants for the MXINT8 block format and the quantizer control FSM.
//   SCALE_WIDTH / MXINT8_ELEMENT_WIDTH / BLOCK_SIZE : block format geometry
//   SCALE_BIAS / SCALE_MAX                          : E8M0 exponent bias and
//                                                     largest non-NaN code
//   MXINT8_FRAC_BITS / MXINT8_ELEM_MAX              : element fixed point and
//                                                     symmetric saturation limit
//   Q_*                                             : quantizer state encodings
// -----------------------------------------------------------------------------
package mxint8_quantizer_pkg;

  localparam int SCALE_WIDTH          = 32'd8;
  localparam int MXINT8_ELEMENT_WIDTH = 32'd8;
  localparam int BLOCK_SIZE           = 32'd32;

  localparam int SCALE_BIAS       = 32'd127;
  localparam int SCALE_MAX        = 32'd254;
  localparam int MXINT8_FRAC_BITS = 32'd6;
  localparam int MXINT8_ELEM_MAX  = 32'd127;

  localparam logic [1:0] Q_COLLECT = 2'd0;
  localparam logic [1:0] Q_SCALE   = 2'd1;
  localparam logic [1:0] Q_CONVERT = 2'd2;
  localparam logic [1:0] Q_OUTPUT  = 2'd3;

  typedef logic [MXINT8_ELEMENT_WIDTH-1:0] mx_elem_t;

endpackage

// File: rtl/mxint8_msb_detect.sv
// -----------------------------------------------------------------------------
// mxint8_msb_detect
// Combinational priority encoder: position of the most-significant set bit.
//   value : unsigned input word
//   pos   : index of the highest set bit (0 when value is zero)
//   zero  : value is all zeros
// -----------------------------------------------------------------------------
module mxint8_msb_detect #(
  parameter int WIDTH     = 17,
  parameter int POS_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     value,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 zero
);

  // Upward scan so the highest set bit wins
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos = value[i] ? POS_WIDTH'(i) : pos;
    end
    zero = (value == '0);
  end

endmodule

// File: rtl/mxint8_quantizer_chk.sv
// -----------------------------------------------------------------------------
// mxint8_quantizer_chk
// Property checker for the quantizer: the biased block exponent must never need
// clamping at the top of the E8M0 range.
//   clk, rst_n  : quantizer clock and asynchronous active-low reset
//   in_scale    : quantizer is in its scale-computation cycle
//   scale_over  : biased exponent computed this cycle exceeds SCALE_MAX
// -----------------------------------------------------------------------------
module mxint8_quantizer_chk (
  input logic clk,
  input logic rst_n,
  input logic in_scale,
  input logic scale_over
);

  // Upper clamp is unreachable for legal IN_WIDTH / IN_FRAC_BITS combinations
  scale_not_clamped_high: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_scale && scale_over));

endmodule

// File: rtl/mxint8_quantizer.sv
// -----------------------------------------------------------------------------
// mxint8_quantizer
// Streaming encoder from signed fixed-point elements to one MXINT8 block
// (shared E8M0 scale + BLOCK_SIZE signed 8-bit elements, value = raw * 2^-6).
// Elements are collected one per cycle while the block maximum magnitude is
// tracked, the scale is derived in one cycle, then every element is rounded
// (nearest-even) and saturated serially into the output register.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_valid / o_ready   : input element handshake
//   i_element           : signed input, value = raw * 2^-IN_FRAC_BITS
//   o_valid / i_ready   : output block handshake
//   o_scale             : E8M0 shared scale, bias 127 (255 never produced)
//   o_mxint8_elements   : BLOCK_SIZE two's-complement elements in [-127, 127]
// -----------------------------------------------------------------------------
module mxint8_quantizer
  import mxint8_quantizer_pkg::*;
#(
  parameter int IN_WIDTH     = 16,
  parameter int IN_FRAC_BITS = 8
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst_n,
  input  logic                                               i_valid,
  output logic                                               o_ready,
  input  logic [IN_WIDTH-1:0]                                i_element,
  output logic                                               o_valid,
  input  logic                                               i_ready,
  output logic [SCALE_WIDTH-1:0]                             o_scale,
  output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]    o_mxint8_elements
);

  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam int ABS_W = IN_WIDTH + 1;            // holds |-2^(IN_WIDTH-1)| exactly
  localparam int POS_W = $clog2(ABS_W);
  localparam int EXP_W = POS_W + 10;              // signed exponent arithmetic
  localparam int SW    = IN_WIDTH + 2;            // rounding datapath width
  localparam int SH_W  = $clog2(SW + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_SIZE - 1);

  logic [1:0]                  state_r;
  logic [1:0]                  state_n_s;
  logic [IDX_W-1:0]            idx_r;
  logic [ABS_W-1:0]            max_abs_r;
  logic [IN_WIDTH-1:0]         elem_buf_r [BLOCK_SIZE];
  logic                        ready_r;
  logic                        valid_r;
  logic [SCALE_WIDTH-1:0]      scale_r;
  logic signed [EXP_W-1:0]     shift_r;
  mx_elem_t [BLOCK_SIZE-1:0]   elems_r;

  logic                        in_hs_s;
  logic                        out_hs_s;
  logic                        idx_last_s;
  logic [ABS_W-1:0]            elem_ext_s;
  logic [ABS_W-1:0]            elem_abs_s;
  logic [POS_W-1:0]            msb_pos_s;
  logic                        max_zero_s;

  logic signed [EXP_W-1:0]     x_s;
  logic signed [EXP_W-1:0]     biased_s;
  logic signed [EXP_W-1:0]     e_eff_s;
  logic signed [EXP_W-1:0]     shift_n_s;
  logic [SCALE_WIDTH-1:0]      scale_n_s;
  logic                        scale_over_s;

  logic [IN_WIDTH-1:0]         raw_s;
  logic signed [SW-1:0]        raw_ext_s;
  logic signed [SW-1:0]        floor_s;
  logic signed [SW-1:0]        q_wide_s;
  logic [SW-1:0]               mask_s;
  logic [SW-1:0]               rem_s;
  logic [SW-1:0]               half_s;
  logic [SH_W-1:0]             rsh_s;
  logic [EXP_W-1:0]            lsh_s;
  logic                        round_up_s;
  mx_elem_t                    q_s;

  assign in_hs_s    = i_valid & ready_r;
  assign out_hs_s   = valid_r & i_ready;
  assign idx_last_s = (idx_r == IDX_LAST);

  assign o_ready           = ready_r;
  assign o_valid           = valid_r;
  assign o_scale           = scale_r;
  assign o_mxint8_elements = elems_r;

  mxint8_msb_detect #(
    .WIDTH     (ABS_W),
    .POS_WIDTH (POS_W)
  ) u_msb_detect (
    .value (max_abs_r),
    .pos   (msb_pos_s),
    .zero  (max_zero_s)
  );

  mxint8_quantizer_chk u_chk (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .in_scale   (state_r == Q_SCALE),
    .scale_over (scale_over_s)
  );

  // Magnitude of the incoming element, one bit wider so the most negative value fits
  always_comb begin
    elem_ext_s = {i_element[IN_WIDTH-1], i_element};
    if (i_element[IN_WIDTH-1]) begin
      elem_abs_s = ~elem_ext_s + ABS_W'(1'b1);
    end else begin
      elem_abs_s = elem_ext_s;
    end
  end

  // Block exponent and E8M0 scale; an underflowing exponent is clamped and the
  // clamp amount is folded into the element shift so elements stay consistent
  always_comb begin
    x_s          = $signed(EXP_W'(msb_pos_s)) - $signed(EXP_W'(IN_FRAC_BITS));
    biased_s     = x_s + $signed(EXP_W'(SCALE_BIAS));
    scale_n_s    = '0;
    e_eff_s      = x_s;
    scale_over_s = 1'b0;
    if (max_zero_s) begin
      scale_n_s = '0;
      e_eff_s   = '0;
    end else if (biased_s[EXP_W-1]) begin
      scale_n_s = '0;
      e_eff_s   = -$signed(EXP_W'(SCALE_BIAS));
    end else if (biased_s > $signed(EXP_W'(SCALE_MAX))) begin
      scale_n_s    = SCALE_WIDTH'(SCALE_MAX);
      e_eff_s      = $signed(EXP_W'(SCALE_MAX - SCALE_BIAS));
      scale_over_s = 1'b1;
    end else begin
      scale_n_s = biased_s[SCALE_WIDTH-1:0];
      e_eff_s   = x_s;
    end
    shift_n_s = e_eff_s + $signed(EXP_W'(IN_FRAC_BITS)) - $signed(EXP_W'(MXINT8_FRAC_BITS));
  end

  // Shared round-half-even / saturate path for the element selected by idx_r.
  // Right shifts beyond SW-1 always round to zero, so the amount is capped there.
  always_comb begin
    raw_s      = elem_buf_r[idx_r];
    raw_ext_s  = $signed({{2{raw_s[IN_WIDTH-1]}}, raw_s});
    rsh_s      = '0;
    lsh_s      = '0;
    floor_s    = '0;
    mask_s     = '0;
    rem_s      = '0;
    half_s     = '0;
    round_up_s = 1'b0;
    q_wide_s   = '0;
    if (!shift_r[EXP_W-1] && (shift_r != '0)) begin
      if (shift_r > $signed(EXP_W'(SW - 1))) begin
        rsh_s = SH_W'(SW - 1);
      end else begin
        rsh_s = SH_W'(shift_r);
      end
      floor_s    = raw_ext_s >>> rsh_s;
      mask_s     = ~({SW{1'b1}} << rsh_s);
      rem_s      = $unsigned(raw_ext_s) & mask_s;
      half_s     = SW'(1'b1) << (rsh_s - SH_W'(1'b1));
      round_up_s = (rem_s > half_s) || ((rem_s == half_s) && floor_s[0]);
      q_wide_s   = floor_s + $signed(SW'(round_up_s));
    end else begin
      lsh_s    = EXP_W'(-shift_r);
      q_wide_s = raw_ext_s <<< lsh_s;
    end

    if (q_wide_s > $signed(SW'(MXINT8_ELEM_MAX))) begin
      q_s = mx_elem_t'(MXINT8_ELEM_MAX);
    end else if (q_wide_s < -$signed(SW'(MXINT8_ELEM_MAX))) begin
      q_s = mx_elem_t'(-MXINT8_ELEM_MAX);
    end else begin
      q_s = q_wide_s[MXINT8_ELEMENT_WIDTH-1:0];
    end
  end

  // Next-state decode
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      Q_COLLECT: begin
        if (in_hs_s && idx_last_s) begin
          state_n_s = Q_SCALE;
        end else begin
          state_n_s = Q_COLLECT;
        end
      end
      Q_SCALE: begin
        state_n_s = Q_CONVERT;
      end
      Q_CONVERT: begin
        if (idx_last_s) begin
          state_n_s = Q_OUTPUT;
        end else begin
          state_n_s = Q_CONVERT;
        end
      end
      Q_OUTPUT: begin
        if (out_hs_s) begin
          state_n_s = Q_COLLECT;
        end else begin
          state_n_s = Q_OUTPUT;
        end
      end
      default: begin
        state_n_s = Q_COLLECT;
      end
    endcase
  end

  // State, datapath registers and registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= Q_COLLECT;
      idx_r     <= '0;
      max_abs_r <= '0;
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      scale_r   <= '0;
      shift_r   <= '0;
      elems_r   <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        elem_buf_r[i] <= '0;
      end
    end else begin
      state_r <= state_n_s;
      ready_r <= (state_n_s == Q_COLLECT);
      valid_r <= (state_n_s == Q_OUTPUT);
      case (state_r)
        Q_COLLECT: begin
          if (in_hs_s) begin
            elem_buf_r[idx_r] <= i_element;
            idx_r             <= idx_last_s ? '0 : idx_r + IDX_W'(1'b1);
            if (elem_abs_s > max_abs_r) begin
              max_abs_r <= elem_abs_s;
            end
          end
        end
        Q_SCALE: begin
          scale_r <= scale_n_s;
          shift_r <= shift_n_s;
          idx_r   <= '0;
        end
        Q_CONVERT: begin
          elems_r[idx_r] <= q_s;
          idx_r          <= idx_last_s ? '0 : idx_r + IDX_W'(1'b1);
        end
        Q_OUTPUT: begin
          if (out_hs_s) begin
            idx_r     <= '0;
            max_abs_r <= '0;
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mxint8_quantizer.sv
// -----------------------------------------------------------------------------
// tb_mxint8_quantizer
// Self-checking bench: each driven block pushes its reference result onto a
// scoreboard queue; results are popped and compared when o_valid is seen.
// -----------------------------------------------------------------------------
module tb_mxint8_quantizer;

  localparam int NB = 32;

  typedef struct packed {
    logic [7:0]          scale;
    logic [NB-1:0][7:0]  el;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [15:0]          i_element;
  logic                 o_valid;
  logic                 i_ready;
  logic [7:0]           o_scale;
  logic [NB-1:0][7:0]   o_elems;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   blk [NB];
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mxint8_quantizer #(.IN_WIDTH(16), .IN_FRAC_BITS(8)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_element         (i_element),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_scale           (o_scale),
    .o_mxint8_elements (o_elems)
  );

  // Reference: magnitude-based round-half-even, symmetric saturation
  function automatic exp_t model();
    exp_t r;
    int mx, a, p, x, b, e, s, q, qa, rm, den;
    r = '0;
    mx = 0;
    for (int i = 0; i < NB; i++) begin
      a = (blk[i] < 0) ? -blk[i] : blk[i];
      if (a > mx) mx = a;
    end
    if (mx == 0) return r;
    p = 0;
    for (int k = 0; k < 31; k++) if (mx >= (1 << k)) p = k;
    x = p - 8;
    b = x + 127;
    if (b < 0) begin r.scale = 8'd0; e = -127; end
    else if (b > 254) begin r.scale = 8'd254; e = 127; end
    else begin r.scale = b[7:0]; e = x; end
    s = e + 2;
    for (int i = 0; i < NB; i++) begin
      a = (blk[i] < 0) ? -blk[i] : blk[i];
      if (s > 0) begin
        if (s > 30) qa = 0;
        else begin
          den = 1 << s;
          qa = a / den;
          rm = a % den;
          if ((2 * rm > den) || ((2 * rm == den) && (qa % 2 == 1))) qa = qa + 1;
        end
        q = (blk[i] < 0) ? -qa : qa;
      end else begin
        q = blk[i] * (1 << (-s));
      end
      if (q > 127) q = 127;
      if (q < -127) q = -127;
      r.el[i] = q[7:0];
    end
    return r;
  endfunction

  task automatic send_elem(input int v);
    bit acc;
    i_valid = 1'b1;
    i_element = v[15:0];
    for (int g = 0; g < 200; g++) begin
      acc = o_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (g == 199) begin
        checks++; errors++;
        $display("FAIL send_timeout: o_ready never high, value %0d", v);
      end
    end
    last_hs = cyc;
    i_valid = 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    sbq.push_back(model());
    for (int i = 0; i < NB; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          checks++;
          if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_ready: idx %0d o_ready=%b want 1", i, o_ready);
          end
        end
      end
      send_elem(blk[i]);
    end
  endtask

  task automatic wait_valid();
    bit busy_ready;
    bit seen;
    busy_ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (o_valid === 1'b1) begin seen = 1'b1; break; end
      if (o_ready !== 1'b0) busy_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL valid_timeout: o_valid=%b want 1 within 200 cycles", o_valid);
    end
    checks++;
    if (busy_ready) begin
      errors++;
      $display("FAIL busy_ready: o_ready=1 seen while converting, want 0");
    end
  endtask

  task automatic accept();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_element = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_scale !== 8'd0 || o_elems !== '0) begin
      errors++;
      $display("FAIL reset_vals: ready=%b valid=%b scale=%0d elems=%h want 0/0/0/0",
               o_ready, o_valid, o_scale, o_elems);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: o_ready=%b want 1", o_ready);
    end
  endtask

  task automatic test_ones();
    exp_t e;
    int h;
    for (int i = 0; i < NB; i++) blk[i] = 256;
    send_block(1'b0);
    h = last_hs;
    wait_valid();
    checks++;
    if (cyc - h !== NB + 1) begin
      errors++;
      $display("FAIL latency: valid rose %0d edges after last handshake, want %0d", cyc - h, NB + 1);
    end
    checks++;
    if (o_scale !== 8'd127 || o_elems[0] !== 8'd64 || o_elems[NB-1] !== 8'd64) begin
      errors++;
      $display("FAIL ones_literal: scale=%0d e0=%0d e31=%0d want 127/64/64", o_scale, o_elems[0], o_elems[NB-1]);
    end
    e = sbq.pop_front();
    checks++;
    if (o_scale !== e.scale) begin
      errors++; $display("FAIL ones_scale: got %0d want %0d", o_scale, e.scale);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (o_elems[i] !== e.el[i]) begin
        errors++; $display("FAIL ones_elem[%0d]: got %h want %h", i, o_elems[i], e.el[i]);
      end
    end
    accept();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ones_release: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [7:0] want_sc [2];
    logic [7:0] want_e0 [2];
    want_sc[0] = 8'd133; want_e0[0] = 8'd127;
    want_sc[1] = 8'd134; want_e0[1] = 8'hC0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NB; i++) blk[i] = 0;
      blk[0] = (t == 0) ? 32767 : -32768;
      send_block(1'b0);
      wait_valid();
      e = sbq.pop_front();
      checks++;
      if (o_scale !== want_sc[t] || o_elems[0] !== want_e0[t]) begin
        errors++;
        $display("FAIL sat_literal%0d: scale=%0d e0=%h want %0d/%h", t, o_scale, o_elems[0], want_sc[t], want_e0[t]);
      end
      checks++;
      if (o_scale !== e.scale || o_elems !== e.el) begin
        errors++;
        $display("FAIL sat_model%0d: scale=%0d elems=%h want %0d/%h", t, o_scale, o_elems, e.scale, e.el);
      end
      accept();
    end
  endtask

  task automatic test_rounding();
    exp_t e;
    for (int i = 0; i < NB; i++) blk[i] = 0;
    blk[0] = 256; blk[1] = 3; blk[2] = 2; blk[3] = 6; blk[4] = -6;
    blk[5] = 10; blk[6] = 14; blk[7] = -10; blk[8] = -255;
    send_block(1'b0);
    wait_valid();
    e = sbq.pop_front();
    checks++;
    if (o_elems[1] !== 8'd1 || o_elems[2] !== 8'd0 || o_elems[3] !== 8'd2 || o_elems[4] !== 8'hFE) begin
      errors++;
      $display("FAIL rne_literal: e1..e4=%h %h %h %h want 01 00 02 fe",
               o_elems[1], o_elems[2], o_elems[3], o_elems[4]);
    end
    checks++;
    if (o_scale !== e.scale) begin
      errors++; $display("FAIL rne_scale: got %0d want %0d", o_scale, e.scale);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (o_elems[i] !== e.el[i]) begin
        errors++; $display("FAIL rne_elem[%0d]: got %h want %h", i, o_elems[i], e.el[i]);
      end
    end
    accept();
  endtask

  task automatic test_zero_small();
    exp_t e;
    for (int i = 0; i < NB; i++) blk[i] = 0;
    send_block(1'b0);
    wait_valid();
    e = sbq.pop_front();
    checks++;
    if (o_scale !== 8'd0 || o_elems !== '0) begin
      errors++; $display("FAIL zero_block: scale=%0d elems=%h want 0/0", o_scale, o_elems);
    end
    accept();
    blk[5] = 1;
    send_block(1'b0);
    wait_valid();
    e = sbq.pop_front();
    checks++;
    if (o_scale !== 8'd119 || o_elems[5] !== 8'd64) begin
      errors++; $display("FAIL tiny_literal: scale=%0d e5=%0d want 119/64", o_scale, o_elems[5]);
    end
    checks++;
    if (o_scale !== e.scale || o_elems !== e.el) begin
      errors++; $display("FAIL tiny_model: scale=%0d elems=%h want %0d/%h", o_scale, o_elems, e.scale, e.el);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int hs_cyc;
    logic [15:0] r16;
    for (int i = 0; i < NB; i++) begin
      r16 = 16'($urandom);
      blk[i] = int'($signed(r16));
    end
    send_block(1'b1);
    wait_valid();
    e = sbq.pop_front();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_scale !== e.scale || o_elems !== e.el) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b ready=%b scale=%0d want 1/0/%0d", c, o_valid, o_ready, o_scale, e.scale);
      end
    end
    accept();
    hs_cyc = cyc;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_release: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
    // Second block of small magnitudes exercises the exact left-shift path
    for (int i = 0; i < NB; i++) blk[i] = int'($urandom_range(0, 40)) - 20;
    sbq.push_back(model());
    send_elem(blk[0]);
    checks++;
    if (last_hs !== hs_cyc + 1) begin
      errors++; $display("FAIL b2b_accept: first element at edge %0d want %0d", last_hs, hs_cyc + 1);
    end
    for (int i = 1; i < NB; i++) send_elem(blk[i]);
    wait_valid();
    e = sbq.pop_front();
    checks++;
    if (o_scale !== e.scale || o_elems !== e.el) begin
      errors++; $display("FAIL b2b_model: scale=%0d elems=%h want %0d/%h", o_scale, o_elems, e.scale, e.el);
    end
    accept();
  endtask

  task automatic test_reset_midblock();
    exp_t e;
    for (int i = 0; i < 17; i++) send_elem((i == 3) ? 32767 : -30000 + i);
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_scale !== 8'd0 || o_elems !== '0) begin
      errors++;
      $display("FAIL midreset_vals: ready=%b valid=%b scale=%0d want 0/0/0 and zero elems",
               o_ready, o_valid, o_scale);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready: o_ready=%b want 1", o_ready);
    end
    for (int i = 0; i < NB; i++) blk[i] = i * 3 - 40;
    send_block(1'b0);
    wait_valid();
    e = sbq.pop_front();
    checks++;
    if (o_scale !== e.scale) begin
      errors++; $display("FAIL midreset_scale: got %0d want %0d", o_scale, e.scale);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (o_elems[i] !== e.el[i]) begin
        errors++; $display("FAIL midreset_elem[%0d]: got %h want %h", i, o_elems[i], e.el[i]);
      end
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_ones();
    test_saturation();
    test_rounding();
    test_zero_small();
    test_back_to_back();
    test_reset_midblock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
